// File: rtl/nios2_cordic_sysid_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios2_cordic_sysid_checker_pkg
// Description : Shared types and constants for the sysid checker.
// Revision    : 1.0 - initial release
// ============================================================================
package nios2_cordic_sysid_checker_pkg;

    // Sequencer states: two reads, one compare, one result cycle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Word offsets inside the sysid slave.
    localparam logic SYSID_OFS_ID = 1'b0;
    localparam logic SYSID_OFS_TS = 1'b1;

    // Width of the read-latency down counter.
    localparam int CNT_W = 4;

endpackage : nios2_cordic_sysid_checker_pkg
`default_nettype wire

// File: rtl/nios2_cordic_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : nios2_cordic_sysid_checker
// Description : Reads the system ID and build timestamp words from a sysid
//               slave, holding each read READ_LATENCY cycles, then compares
//               them with the expected values and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_cordic_sysid_checker
    import nios2_cordic_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1457789265,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match
);

    // Counter value loaded at the start of each read: the read is held for
    // LOAD+1 cycles and sampled on the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(READ_LATENCY - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               cap_id;
    logic               cap_ts;
    logic               do_cmp;

    // State and latency counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and bus/status outputs.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        cap_id        = 1'b0;
        cap_ts        = 1'b0;
        do_cmp        = 1'b0;
        sysid_read    = 1'b0;
        sysid_address = SYSID_OFS_ID;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = RD_ID;
                    cnt_next   = LOAD;
                end
            end
            RD_ID: begin
                sysid_read    = 1'b1;
                sysid_address = SYSID_OFS_ID;
                if (cnt == '0) begin
                    cap_id     = 1'b1;
                    cnt_next   = LOAD;
                    state_next = RD_TS;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RD_TS: begin
                sysid_read    = 1'b1;
                sysid_address = SYSID_OFS_TS;
                if (cnt == '0) begin
                    cap_ts     = 1'b1;
                    cnt_next   = LOAD;
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            CHECK: begin
                do_cmp     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Captured words and compare results; held until the next update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= '0;
            ts_value <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            match    <= 1'b0;
        end else begin
            if (cap_id) begin
                id_value <= sysid_readdata;
            end
            if (cap_ts) begin
                ts_value <= sysid_readdata;
            end
            if (do_cmp) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TS);
                match <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
            end
        end
    end

endmodule : nios2_cordic_sysid_checker
`default_nettype wire

// File: tb/tb_nios2_cordic_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_cordic_sysid_checker
// Description : Directed bench for the sysid checker, with READ_LATENCY=1
//               (dut_a) and READ_LATENCY=3 (dut_b) instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_cordic_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1457789265;
    localparam logic [31:0] TS_BAD  = 32'h5699_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [31:0] id_word = 32'd0;
    logic [31:0] ts_word = TS_GOOD;

    logic        addr_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, match_a;
    logic [31:0] rdata_a, id_value_a, ts_value_a;
    logic        addr_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, match_b;
    logic [31:0] rdata_b, id_value_b, ts_value_b;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Sysid slave models: combinational data by offset while read is high.
    assign rdata_a = read_a ? (addr_a ? ts_word : id_word) : 32'hDEAD_BEEF;
    assign rdata_b = read_b ? (addr_b ? ts_word : id_word) : 32'hDEAD_BEEF;

    nios2_cordic_sysid_checker #(.READ_LATENCY(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a),
        .sysid_address(addr_a), .sysid_read(read_a), .sysid_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_value(id_value_a), .ts_value(ts_value_a),
        .id_ok(id_ok_a), .ts_ok(ts_ok_a), .match(match_a)
    );

    nios2_cordic_sysid_checker #(.READ_LATENCY(3)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .sysid_address(addr_b), .sysid_read(read_b), .sysid_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_value(id_value_b), .ts_value(ts_value_b),
        .id_ok(id_ok_b), .ts_ok(ts_ok_b), .match(match_b)
    );

    task automatic test_reset();
        logic [8:0] got;
        repeat (3) @(negedge clock);
        got = {addr_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, match_a, addr_b, read_b};
        total++;
        if (got !== 9'd0) begin
            bad++; $display("FAIL reset_flags got=%b want=%b", got, 9'd0);
        end
        total++;
        if ({id_value_a, ts_value_a} !== 64'd0) begin
            bad++; $display("FAIL reset_values got=%h want=0", {id_value_a, ts_value_a});
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // One READ_LATENCY=1 sequence; k counts negedges after the start edge.
    task automatic run_seq_a(input string name, input logic [31:0] ts,
                             input logic exp_id_ok, input logic exp_ts_ok);
        logic [3:0] got, want;
        ts_word = ts;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            got  = {busy_a, read_a, addr_a, done_a};
            want = {k <= 3, k <= 1, k == 1, k == 3};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL %s_wave k=%0d got=%b want=%b", name, k, got, want);
            end
        end
        total++;
        if ({id_ok_a, ts_ok_a, match_a} !== {exp_id_ok, exp_ts_ok, exp_id_ok & exp_ts_ok}) begin
            bad++; $display("FAIL %s_flags got=%b want=%b", name,
                            {id_ok_a, ts_ok_a, match_a}, {exp_id_ok, exp_ts_ok, exp_id_ok & exp_ts_ok});
        end
        total++;
        if ({id_value_a, ts_value_a} !== {id_word, ts}) begin
            bad++; $display("FAIL %s_values got=%h want=%h", name, {id_value_a, ts_value_a}, {id_word, ts});
        end
    endtask

    task automatic test_match();
        run_seq_a("match", TS_GOOD, 1'b1, 1'b1);
    endtask

    task automatic test_ts_mismatch();
        run_seq_a("ts_bad", TS_BAD, 1'b1, 1'b0);
        // Results stay put through idle cycles.
        repeat (3) @(negedge clock);
        total++;
        if ({ts_value_a, id_ok_a, ts_ok_a, match_a} !== {TS_BAD, 3'b100}) begin
            bad++; $display("FAIL idle_hold got=%h want=%h", {ts_value_a, id_ok_a, ts_ok_a, match_a}, {TS_BAD, 3'b100});
        end
        // A one-bit difference at the low end must also miss.
        run_seq_a("ts_lsb", TS_GOOD ^ 32'd1, 1'b1, 1'b0);
    endtask

    task automatic test_latency3();
        logic [3:0] got, want;
        ts_word = TS_GOOD;
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clock);
            got  = {busy_b, read_b, addr_b, done_b};
            want = {k <= 7, k <= 5, (k >= 3) && (k <= 5), k == 7};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL lat3_wave k=%0d got=%b want=%b", k, got, want);
            end
        end
        total++;
        if ({match_b, ts_value_b} !== {1'b1, TS_GOOD}) begin
            bad++; $display("FAIL lat3_result got=%h want=%h", {match_b, ts_value_b}, {1'b1, TS_GOOD});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] got, want;
        ts_word = TS_GOOD;
        start_a = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clock);
            if (k == 19) start_a = 1'b0;
            got  = {busy_a, done_a};
            want = {(k % 5) != 4, (k % 5) == 3};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL b2b k=%0d got=%b want=%b", k, got, want);
            end
        end
        @(negedge clock);
        total++;
        if (busy_a !== 1'b0) begin
            bad++; $display("FAIL b2b_end busy got=%b want=0", busy_a);
        end
    endtask

    task automatic test_ignore_start();
        logic [1:0] got, want;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clock);
            if (k == 2) start_a = 1'b1;   // sampled at the CHECK and DONE edges
            if (k == 4) start_a = 1'b0;
            got  = {busy_a, done_a};
            want = {k <= 3, k == 3};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL ignore k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);                 // dut_a in RD_TS
        #2 reset_n = 1'b0;
        #1;
        got = {busy_a, read_a, addr_a, done_a, match_a, id_ok_a};
        total++;
        if (got !== 6'd0) begin
            bad++; $display("FAIL rst_mid_flags got=%b want=0", got);
        end
        total++;
        if ({id_value_a, ts_value_a} !== 64'd0) begin
            bad++; $display("FAIL rst_mid_values got=%h want=0", {id_value_a, ts_value_a});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total++;
            if ({busy_a, done_a} !== 2'b00) begin
                bad++; $display("FAIL rst_mid_quiet k=%0d got=%b want=00", k, {busy_a, done_a});
            end
        end
        // Start presented on the very first edge after release.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_seq_a("post_rst", TS_GOOD, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_match();
        test_ts_mismatch();
        test_latency3();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nios2_cordic_sysid_checker
`default_nettype wire

// File: doc/nios2_cordic_sysid_checker.md
NIOS2_CORDIC_SYSID_CHECKER -- requirements
Module: nios2_cordic_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0, the system ID value the checker requires at sysid offset 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1457789265, the build timestamp the checker requires at sysid offset 1.
REQ-003 SHALL have parameter READ_LATENCY, default 1, range 1..15, the number of cycles each read is held before readdata is sampled.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, request for one check sequence.
REQ-007 SHALL have port sysid_address, output, 1, word offset presented to the sysid slave.
REQ-008 SHALL have port sysid_read, output, 1, read strobe to the sysid slave.
REQ-009 SHALL have port sysid_readdata, input, 32, data returned by the sysid slave.
REQ-010 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-012 SHALL have ports id_value and ts_value, output, 32 each, the captured words.
REQ-013 SHALL have ports id_ok, ts_ok and match, output, 1 each: per-word compare results and their AND.

Function
REQ-014 SHALL implement FSM states IDLE, RD_ID, RD_TS, CHECK, DONE.
REQ-015 IDLE: start=1 at an edge SHALL move to RD_ID and load the latency counter with READ_LATENCY-1.
REQ-016 RD_ID SHALL drive sysid_read=1 and sysid_address=0, and SHALL decrement the counter each cycle.
REQ-017 In RD_ID, with counter==0, the edge SHALL capture sysid_readdata into id_value, reload the counter and move to RD_TS.
REQ-018 RD_TS SHALL behave like RD_ID with sysid_address=1, capture into ts_value, then move to CHECK.
REQ-019 CHECK SHALL register id_ok=(id_value==EXPECTED_ID), ts_ok=(ts_value==EXPECTED_TS) and match=id_ok&ts_ok, then move to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Latency: with start sampled at edge E0, done SHALL be high during the cycle after edge E0+2*READ_LATENCY+1.
REQ-022 busy SHALL be high in RD_ID, RD_TS, CHECK and DONE, and low in IDLE.
REQ-023 sysid_read and sysid_address SHALL be 0 outside RD_ID and RD_TS.
REQ-024 start while not in IDLE, including the DONE cycle, SHALL be ignored; it is not queued.
REQ-025 id_value, ts_value, id_ok, ts_ok and match SHALL hold their last values until the next capture or compare and SHALL remain stable in IDLE.
REQ-026 The compare SHALL be exact 32-bit equality; there is no masking.
REQ-027 The counter SHALL be 4 bits wide, SHALL only count down, and SHALL never wrap (it is reloaded at 0).

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, counter 0, all outputs 0, and id_value and ts_value to 0.
REQ-029 Reset asserted mid-sequence SHALL abort it, with no done pulse; a sequence SHALL start only on a fresh start after release.
REQ-030 The first edge after reset_n rises SHALL be able to accept start.

Structure
REQ-031 The shared package SHALL hold the state enum, SYSID_OFS_ID=1'b0, SYSID_OFS_TS=1'b1, and the counter width constant.
REQ-032 The block SHALL be a single module with no sub-module; the FSM and counter are inline.

Verification
REQ-033 Scenario: READ_LATENCY=1, slave returning 0 at offset 0 and 1457789265 at offset 1, start pulse at E0 -> done during the cycle after E3 (per REQ-021), match=1, id_ok=1, ts_ok=1, id_value=0, ts_value=1457789265.
REQ-034 Scenario: slave returns 0x5699_0000 at offset 1 -> ts_ok=0, id_ok=1, match=0, ts_value=0x56990000.
REQ-035 Scenario: READ_LATENCY=3, start at E0 -> sysid_read high for 6 cycles (address 0 for 3 cycles, then 1 for 3), done during the cycle after E7.
REQ-036 Scenario: start held high for 20 cycles, READ_LATENCY=1 -> a new sequence begins on the first edge in IDLE after each DONE, and every done is 1 cycle wide.
REQ-037 Scenario: reset_n pulled low during RD_TS -> outputs 0 asynchronously, no done pulse; a new start after release gives a normal result.
REQ-038 Scenario: start asserted during CHECK or DONE -> ignored, and busy falls after DONE.
